// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, divide-error value and driver FSM states shared with the ALU.
package alu_pkg;
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_DIV  = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_NOTB = 3'd7;
  localparam logic [7:0] DIV_ERR_VALUE = 8'hFF;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: valid/ready command front end that drives the external ALU and returns its result.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_s,
  input  logic [7:0]       alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic [2:0]       rsp_op,
  output logic             rsp_err,
  output logic [CNT_W-1:0] done_cnt
);
  state_t st;
  logic   div_err;
  assign cmd_ready = st == IDLE;
  assign rsp_valid = st == RESP;
  assign div_err   = alu_s == OP_DIV && alu_b == 4'd0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= IDLE;
      alu_a    <= 4'd0;
      alu_b    <= 4'd0;
      alu_s    <= 3'd0;
      rsp_data <= 8'h00;
      rsp_op   <= 3'd0;
      rsp_err  <= 1'b0;
      done_cnt <= '0;
    end else begin
      case (st)
        IDLE: if (cmd_valid) begin
          alu_a <= cmd_a;
          alu_b <= cmd_b;
          alu_s <= cmd_op;
          st    <= EXEC;
        end
        EXEC: begin
          // a divide by zero has no defined ALU result, so never pass alu_y through
          rsp_data <= div_err ? DIV_ERR_VALUE : alu_y;
          rsp_op   <= alu_s;
          rsp_err  <= div_err;
          st       <= RESP;
        end
        RESP: if (rsp_ready) begin
          done_cnt <= done_cnt + CNT_W'(1);
          st       <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
